// File: rtl/fifo_rd_burst_drain.sv
// -----------------------------------------------------------------------------
// fifo_rd_burst_drain
//
// Read-side consumer of the asynchronous FIFO. The whole block is in the read
// clock domain.
//
// Words are popped through the FIFO's r_empty/r_en/rdata interface into a
// 2-entry output buffer. They leave as a valid/ready stream that is framed into
// fixed-length bursts of BURST_LEN words. The final word of each burst carries
// out_last.
//
// A run/stop FSM only returns to IDLE on a burst boundary, so downstream never
// sees a partial burst. The one exception is an asynchronous reset: it abandons
// the current burst and discards the buffer.
//
// Parameters
//   MEMORY_WIDTH  data word width (must equal the FIFO's MEMORY_WIDTH)
//   BURST_LEN     words per burst, 2..256
//   BEAT_W        beat counter width, 2**BEAT_W >= BURST_LEN
//   CNT_W         completed-burst counter width
//
// Ports
//   r_clk      read-domain clock, rising edge
//   rrst_n     async active-low reset (release already synchronised upstream)
//   r_empty    FIFO empty flag
//   rdata      FIFO read data, valid whenever r_empty=0
//   r_en       FIFO pop strobe
//   run        level request: 1 = drain bursts, 0 = stop at next boundary
//   out_ready  downstream accept
//   out_valid  stream word valid
//   out_data   stream word
//   out_last   final word of a burst, qualified by out_valid
//   busy       FSM not idle or buffer not empty
//   burst_cnt  bursts completed at the output side, wraps
// -----------------------------------------------------------------------------
module fifo_rd_burst_drain #(
  parameter int MEMORY_WIDTH = 8,
  parameter int BURST_LEN    = 4,
  parameter int BEAT_W       = 8,
  parameter int CNT_W        = 16
) (
  input  logic                    r_clk,
  input  logic                    rrst_n,
  input  logic                    r_empty,
  input  logic [MEMORY_WIDTH-1:0] rdata,
  output logic                    r_en,
  input  logic                    run,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [MEMORY_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic [CNT_W-1:0]        burst_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  // Beat index of the next pop. It wraps after the last word of a burst.
  function automatic logic [BEAT_W-1:0] next_beat(input logic [BEAT_W-1:0] b);
    next_beat = (b == LAST_BEAT) ? '0 : b + BEAT_W'(1);
  endfunction

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    push;
  logic                    out_fire;
  logic                    tail_last;

  // Output buffer. Entry p0 is the head and p1 sits behind it.
  // vld_p1 can only be set while vld_p0 is set.
  logic [MEMORY_WIDTH-1:0] data_p0, data_p1;
  logic                    last_p0, last_p1;
  logic                    vld_p0, vld_p1;

  // A pop depends only on registered state, registered occupancy and r_empty.
  // out_ready is deliberately kept off this path.
  assign push      = (state_q != IDLE) && !r_empty && !vld_p1;
  assign r_en      = push;
  assign tail_last = (beat_q == LAST_BEAT);
  assign beat_d    = push ? next_beat(beat_q) : beat_q;

  assign out_fire  = vld_p0 && out_ready;
  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_last  = last_p0;
  assign busy      = (state_q != IDLE) || vld_p0;

  // The RUN exit decision uses the beat value after this cycle's pop. A pop
  // that starts a new burst in the same cycle as run falls therefore forces
  // STOP rather than IDLE, so that burst is always completed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (run) state_d = RUN;
      RUN: begin
        if (!run) state_d = (beat_d == '0) ? IDLE : STOP;
      end
      STOP: if (push && tail_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // ---- Output buffer: FIFO pop -> p1/p0 -> stream ----
  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      data_p0 <= '0;
      last_p0 <= 1'b0;
      vld_p0  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (out_fire) begin
      // The head leaves. A push can only coincide with it when p1 is empty.
      if (vld_p1) begin
        data_p0 <= data_p1;
        last_p0 <= last_p1;
        vld_p1  <= 1'b0;
      end else if (push) begin
        data_p0 <= rdata;
        last_p0 <= tail_last;
      end else begin
        vld_p0  <= 1'b0;
      end
    end else if (push) begin
      if (!vld_p0) begin
        data_p0 <= rdata;
        last_p0 <= tail_last;
        vld_p0  <= 1'b1;
      end else begin
        data_p1 <= rdata;
        last_p1 <= tail_last;
        vld_p1  <= 1'b1;
      end
    end
  end

  // ---- Output side: completed-burst count ----
  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      burst_cnt <= '0;
    end else if (out_fire && last_p0) begin
      burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

endmodule
